apb_csr_bank: RTL and testbench

Parametrised APB slave register bank: next-generation control/status block with configurable data width, register count, wait states, byte strobes and a multi-channel latched interrupt controller. Sits between the system APB bridge and a peripheral core. Exposes RW control registers, a read-only ID register, a W1C interrupt status register and an interrupt mask register. Drives a single level interrupt to the system interrupt controller.

---
 rtl/apb_csr_bank.sv | 186 ++++++++++++++++++
 tb/tb_apb_csr_bank.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_csr_bank.sv
// apb_csr_bank
//   APB slave control/status register bank for a peripheral core.
//   Register index i sits at byte address BASE_ADDR + i*STRB:
//     0..W-1 : CTRL   read/write, byte-strobed
//     W      : ID     read-only constant
//     W+1    : STATUS latched interrupt flags, write-1-to-clear
//     W+2    : MASK   interrupt enables, byte-strobed
//   Ports:
//     clk, rst           clock (rising edge) and async active-high reset
//     addr, sel, en      APB address / select / enable
//     write, strb, wdata APB write direction, byte strobes, write data
//     rdata, ready       read data and transfer completion (combinational)
//     slv_err            error response, qualified by ready (combinational)
//     intrpt             level interrupt sources, synchronous to clk
//     irq                registered OR of enabled pending interrupts
module apb_csr_bank #(
  parameter int unsigned ADDRESS_SIZE     = 32,
  parameter int unsigned REG_WIDTH        = 32,
  parameter int unsigned WRITE_REG_NUMBER = 4,
  parameter logic [ADDRESS_SIZE-1:0] BASE_ADDR = ADDRESS_SIZE'(32'h0000_0100),
  parameter int unsigned WAIT_STATES      = 0,
  parameter int unsigned INTR_NUMBER      = 4,
  parameter logic [REG_WIDTH-1:0] RW_DEFAULT = '0,
  parameter logic [REG_WIDTH-1:0] ID_VALUE   = REG_WIDTH'(32'hA5C0_0001)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDRESS_SIZE-1:0]   addr,
  input  logic                      sel,
  input  logic                      en,
  input  logic                      write,
  input  logic [REG_WIDTH/8-1:0]    strb,
  input  logic [REG_WIDTH-1:0]      wdata,
  output logic [REG_WIDTH-1:0]      rdata,
  output logic                      ready,
  output logic                      slv_err,
  input  logic [INTR_NUMBER-1:0]    intrpt,
  output logic                      irq
);

  localparam int unsigned STRB       = REG_WIDTH / 8;
  localparam int unsigned REG_NUMBER = WRITE_REG_NUMBER + 3;
  localparam int unsigned ID_IDX     = WRITE_REG_NUMBER;
  localparam int unsigned STAT_IDX   = WRITE_REG_NUMBER + 1;
  localparam int unsigned MASK_IDX   = WRITE_REG_NUMBER + 2;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [REG_WIDTH-1:0]    r_ctrl [WRITE_REG_NUMBER];
  logic [INTR_NUMBER-1:0]  r_status;
  logic [INTR_NUMBER-1:0]  r_mask;
  logic [INTR_NUMBER-1:0]  r_intrpt_q;

  logic [ADDRESS_SIZE-1:0] w_off;
  logic [ADDRESS_SIZE-1:0] w_idx;
  logic                    w_err;
  logic                    w_done;
  logic                    w_wr_ok;
  logic                    w_wr_stat;
  logic                    w_wr_mask;
  logic [REG_WIDTH-1:0]    w_rd_val;
  logic [INTR_NUMBER-1:0]  w_set;
  logic [INTR_NUMBER-1:0]  w_clr;

  // Address decode; the offset is only meaningful when addr >= BASE_ADDR.
  assign w_off  = addr - BASE_ADDR;
  assign w_idx  = w_off / ADDRESS_SIZE'(STRB);
  assign w_err  = (addr < BASE_ADDR)
               || ((w_off % ADDRESS_SIZE'(STRB)) != '0)
               || (w_idx >= ADDRESS_SIZE'(REG_NUMBER))
               || (write && (w_idx == ADDRESS_SIZE'(ID_IDX)));

  // Completion cycle: access phase, wait states exhausted, master still enabled.
  assign w_done    = (r_state == S_ACCESS) && (r_cnt == '0) && sel && en;
  assign w_wr_ok   = w_done && write && !w_err;
  assign w_wr_stat = w_wr_ok && (w_idx == ADDRESS_SIZE'(STAT_IDX));
  assign w_wr_mask = w_wr_ok && (w_idx == ADDRESS_SIZE'(MASK_IDX));

  assign ready   = w_done;
  assign slv_err = w_done && w_err;
  assign rdata   = (w_done && !write && !w_err) ? w_rd_val : '0;

  // Read mux over the whole map.
  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < int'(WRITE_REG_NUMBER); i++) begin
      if (w_idx == ADDRESS_SIZE'(i)) w_rd_val = r_ctrl[i];
    end
    if (w_idx == ADDRESS_SIZE'(ID_IDX))   w_rd_val = ID_VALUE;
    if (w_idx == ADDRESS_SIZE'(STAT_IDX)) w_rd_val = REG_WIDTH'(r_status);
    if (w_idx == ADDRESS_SIZE'(MASK_IDX)) w_rd_val = REG_WIDTH'(r_mask);
  end

  // Rising-edge detect on sources, and W1C clear limited to strobed lanes.
  assign w_set = intrpt & ~r_intrpt_q;

  always_comb begin
    w_clr = '0;
    for (int k = 0; k < int'(INTR_NUMBER); k++) begin
      w_clr[k] = w_wr_stat && wdata[k] && strb[k/8];
    end
  end

  // Transfer FSM. IDLE and SETUP both wait for a setup phase; SETUP marks the
  // cycle right after a completion so a back-to-back setup is accepted there.
  // The setup cycle itself is observed from IDLE/SETUP, so ACCESS starts in
  // the master's first access cycle with the wait counter already loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_SETUP: begin
          if (sel && !en) begin
            r_state <= S_ACCESS;
            r_cnt   <= CNT_W'(WAIT_STATES);
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ACCESS: begin
          if (!sel) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else if (en) begin
            r_state <= S_SETUP;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // CTRL registers, byte-lane writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(WRITE_REG_NUMBER); i++) r_ctrl[i] <= RW_DEFAULT;
    end else begin
      for (int i = 0; i < int'(WRITE_REG_NUMBER); i++) begin
        for (int b = 0; b < int'(STRB); b++) begin
          if (w_wr_ok && (w_idx == ADDRESS_SIZE'(i)) && strb[b]) begin
            r_ctrl[i][b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  // MASK register, only the implemented interrupt bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask <= '0;
    end else begin
      for (int k = 0; k < int'(INTR_NUMBER); k++) begin
        if (w_wr_mask && strb[k/8]) r_mask[k] <= wdata[k];
      end
    end
  end

  // STATUS flags: a new edge wins over a coincident W1C clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_intrpt_q <= '0;
      r_status   <= '0;
      irq        <= 1'b0;
    end else begin
      r_intrpt_q <= intrpt;
      r_status   <= (r_status & ~w_clr) | w_set;
      irq        <= |(r_status & r_mask);
    end
  end

endmodule

// File: tb/tb_apb_csr_bank.sv
module tb_apb_csr_bank;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned WS  = 2;
  localparam int unsigned NI  = 4;
  localparam int          CYC = WS + 1;

  logic          clk;
  logic          rst;
  logic [AW-1:0] addr;
  logic          sel;
  logic          en;
  logic          write;
  logic [3:0]    strb;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ready;
  logic          slv_err;
  logic [NI-1:0] intrpt;
  logic          irq;

  apb_csr_bank #(
    .ADDRESS_SIZE    (AW),
    .REG_WIDTH       (DW),
    .WRITE_REG_NUMBER(4),
    .BASE_ADDR       (32'h0000_0100),
    .WAIT_STATES     (WS),
    .INTR_NUMBER     (NI),
    .RW_DEFAULT      (32'h0),
    .ID_VALUE        (32'hA5C0_0001)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .sel    (sel),
    .en     (en),
    .write  (write),
    .strb   (strb),
    .wdata  (wdata),
    .rdata  (rdata),
    .ready  (ready),
    .slv_err(slv_err),
    .intrpt (intrpt),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [31:0] a, input logic wr, input logic [3:0] s,
                         input logic [31:0] d, input logic [31:0] e_rd, input logic e_err);
    vec_t v;
    v.addr = a; v.wr = wr; v.strb = s; v.wdata = d; v.exp_rd = e_rd; v.exp_err = e_err;
    vecs.push_back(v);
  endtask

  // One APB transfer starting just after a rising edge. Expected response is
  // queued at drive time and compared when ready is seen. 'pulse' bits are
  // raised on intrpt during the completion cycle.
  task automatic xfer(input logic [31:0] a, input logic wr, input logic [3:0] s,
                      input logic [31:0] d, input logic [31:0] e_rd, input logic e_err,
                      input logic [3:0] pulse);
    exp_t e;
    exp_t got_e;
    int   cyc;
    bit   got;
    string tag;
    tag = $sformatf("%s@%0h", wr ? "wr" : "rd", a);
    e.rdata = e_rd;
    e.err   = e_err;
    sb.push_back(e);
    addr = a; write = wr; strb = s; wdata = d; sel = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    en  = 1'b1;
    cyc = 1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (ready) begin
        got   = 1'b1;
        got_e = sb.pop_front();
        chk({tag, " rdata"}, rdata, got_e.rdata);
        chk({tag, " slv_err"}, 32'(slv_err), 32'(got_e.err));
        chk({tag, " latency"}, 32'(cyc), 32'(CYC));
        intrpt = intrpt | pulse;
      end else begin
        cyc++;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: got no ready expected ready", tag);
      if (sb.size() > 0) sb.delete(0);
    end
    @(posedge clk); #1;
    sel = 1'b0;
    en  = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b1; sel = 1'b0; en = 1'b0; write = 1'b0; addr = '0; strb = '0; wdata = '0;
    intrpt = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", 32'(ready), 32'd0);
    chk("reset slv_err", 32'(slv_err), 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset irq", 32'(irq), 32'd0);
    rst = 1'b0;
    tick(1);

    // Vector table: applied back to back in order.
    add_vec(32'h100, 0, 4'h0, 32'h0,        32'h0,        0);
    add_vec(32'h110, 0, 4'h0, 32'h0,        32'hA5C00001, 0);
    add_vec(32'h114, 0, 4'h0, 32'h0,        32'h0,        0);
    add_vec(32'h118, 0, 4'h0, 32'h0,        32'h0,        0);
    add_vec(32'h104, 1, 4'b0101, 32'hDEADBEEF, 32'h0,     0);
    add_vec(32'h104, 0, 4'h0, 32'h0,        32'h00AD00EF, 0);
    add_vec(32'h104, 1, 4'hF, 32'hDEADBEEF, 32'h0,        0);
    add_vec(32'h104, 0, 4'h0, 32'h0,        32'hDEADBEEF, 0);
    add_vec(32'h110, 1, 4'hF, 32'h12345678, 32'h0,        1);
    add_vec(32'h11C, 0, 4'h0, 32'h0,        32'h0,        1);
    add_vec(32'h102, 0, 4'h0, 32'h0,        32'h0,        1);
    add_vec(32'h0FC, 0, 4'h0, 32'h0,        32'h0,        1);
    add_vec(32'h11C, 1, 4'hF, 32'hFFFFFFFF, 32'h0,        1);
    add_vec(32'h110, 0, 4'h0, 32'h0,        32'hA5C00001, 0);
    add_vec(32'h108, 1, 4'b1010, 32'h11223344, 32'h0,     0);
    add_vec(32'h108, 0, 4'h0, 32'h0,        32'h11003300, 0);
    add_vec(32'h118, 1, 4'b1110, 32'hFFFFFFFF, 32'h0,     0);
    add_vec(32'h118, 0, 4'h0, 32'h0,        32'h0,        0);
    add_vec(32'h10C, 1, 4'hF, 32'hCAFEF00D, 32'h0,        0);
    add_vec(32'h10C, 0, 4'h0, 32'h0,        32'hCAFEF00D, 0);
    add_vec(32'h100, 0, 4'h0, 32'h0,        32'h0,        0);
    foreach (vecs[i]) begin
      xfer(vecs[i].addr, vecs[i].wr, vecs[i].strb, vecs[i].wdata,
           vecs[i].exp_rd, vecs[i].exp_err, 4'h0);
    end

    // Latched interrupt with mask off, then enable, then W1C.
    intrpt = 4'b0100; tick(1); intrpt = '0; tick(1);
    chk("irq masked", 32'(irq), 32'd0);
    xfer(32'h114, 0, 4'h0, 32'h0, 32'h4, 0, 4'h0);
    xfer(32'h118, 1, 4'hF, 32'h4, 32'h0, 0, 4'h0);
    chk("irq before mask edge", 32'(irq), 32'd0);
    tick(1);
    chk("irq after mask", 32'(irq), 32'd1);
    xfer(32'h114, 1, 4'hF, 32'h4, 32'h0, 0, 4'h0);
    chk("irq one cycle after w1c", 32'(irq), 32'd1);
    tick(1);
    chk("irq cleared", 32'(irq), 32'd0);
    xfer(32'h114, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0);

    // W1C with its byte lane unstrobed must not clear.
    intrpt = 4'b0100; tick(1); intrpt = '0; tick(1);
    xfer(32'h114, 1, 4'b1110, 32'hF, 32'h0, 0, 4'h0);
    xfer(32'h114, 0, 4'h0, 32'h0, 32'h4, 0, 4'h0);
    xfer(32'h114, 1, 4'hF, 32'h4, 32'h0, 0, 4'h0);
    xfer(32'h114, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0);

    // Set wins over a coincident clear; a held level does not re-set.
    intrpt = 4'b0010; tick(1); intrpt = '0; tick(1);
    xfer(32'h114, 0, 4'h0, 32'h0, 32'h2, 0, 4'h0);
    xfer(32'h114, 1, 4'hF, 32'h2, 32'h0, 0, 4'b0010);
    xfer(32'h114, 0, 4'h0, 32'h0, 32'h2, 0, 4'h0);
    xfer(32'h114, 1, 4'hF, 32'h2, 32'h0, 0, 4'h0);
    xfer(32'h114, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0);
    intrpt = '0; tick(1);

    // Aborted write: sel drops during wait states.
    xfer(32'h100, 1, 4'hF, 32'h13579BDF, 32'h0, 0, 4'h0);
    addr = 32'h100; write = 1'b1; strb = 4'hF; wdata = 32'h55AA55AA; sel = 1'b1; en = 1'b0;
    tick(1);
    en = 1'b1;
    tick(1);
    sel = 1'b0; en = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    tick(1);
    chk("abort no ready", 32'(seen), 32'd0);
    xfer(32'h100, 0, 4'h0, 32'h0, 32'h13579BDF, 0, 4'h0);

    // Reset asserted in the completion cycle of a write.
    intrpt = 4'b0100; tick(1); intrpt = '0; tick(2);
    chk("irq before reset", 32'(irq), 32'd1);
    addr = 32'h108; write = 1'b1; strb = 4'hF; wdata = 32'hFFFFFFFF; sel = 1'b1; en = 1'b0;
    tick(1);
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("ready before reset", 32'(ready), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst ready", 32'(ready), 32'd0);
    chk("rst slv_err", 32'(slv_err), 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst irq", 32'(irq), 32'd0);
    sel = 1'b0; en = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    xfer(32'h100, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0);
    xfer(32'h108, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0);
    xfer(32'h10C, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0);
    xfer(32'h114, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0);
    xfer(32'h118, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
